uart_rx_fifo: RTL and testbench

Receive-side buffer directly downstream of the UART receiver. Captures each received byte, announced by a data byte plus data-enable, into a circular FIFO. Presents bytes to the host/bus side with first-word-fall-through reads, so the host need not service every byte at baud rate.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_fifo_edge_detect_rise.sv | 27 ++
 rtl/uart_rx_fifo.sv | 135 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte type and FIFO status flags, used by the RX FIFO
// and the planned TX FIFO.
package uart_pkg;

    localparam int unsigned UART_WIDTH = 8;

    typedef logic [UART_WIDTH-1:0] uart_byte_t;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
    } fifo_status_t;

    // Status flags for a given occupancy.
    function automatic fifo_status_t fifo_status(
        input int unsigned cnt,
        input int unsigned depth,
        input int unsigned af_level
    );
        fifo_status_t s;
        s.empty       = (cnt == 32'd0);
        s.full        = (cnt == depth);
        s.almost_full = (cnt >= af_level);
        return s;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_edge_detect_rise.sv
// edge_detect_rise: one-cycle pulse on each 0->1 transition of i_d.
// The reset value of the history bit is a parameter so a level held high through reset is not seen as an edge.
module edge_detect_rise
    import uart_pkg::*;
#(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    // History of i_d from the previous cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: edge-triggered writes, first-word-fall-through reads.
// Optional overrun reporting (overrun_o, ovrClr_i, dropCnt_o) when UART_RX_FIFO_OVERRUN_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH    = UART_WIDTH,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
`ifdef UART_RX_FIFO_OVERRUN_EN
    input  logic                       ovrClr_i,
    output logic                       overrun_o,
    output logic [7:0]                 dropCnt_o,
`endif
    input  logic [WIDTH-1:0]           dat_i,
    input  logic                       datEn_i,
    input  logic                       rdEn_i,
    output logic [WIDTH-1:0]           dat_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       almostFull_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    fifo_status_t     r_status;

    logic             w_push_edge;
    logic             w_pop;
    logic             w_wr;
    logic             w_drop;
    logic [CW-1:0]    w_count_nxt;
    fifo_status_t     w_status_nxt;

    edge_detect_rise #(
        .RST_VAL (1'b1)
    ) u_dat_en_edge (
        .i_clk  (clk_i),
        .i_rst  (rst_i),
        .i_d    (datEn_i),
        .o_rise (w_push_edge)
    );

    // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
    assign w_pop  = rdEn_i & ~r_status.empty;
    assign w_wr   = w_push_edge & (~r_status.full | w_pop);
    assign w_drop = w_push_edge & r_status.full & ~w_pop;

    // Next occupancy and the flags derived from it.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
        w_status_nxt = fifo_status(32'(w_count_nxt), DEPTH, AF_LEVEL);
    end

    // Storage array; contents are discarded by clearing pointers, not by reset.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= dat_i;
        end
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
            r_status <= '{empty: 1'b1, full: 1'b0, almost_full: 1'b0};
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count  <= w_count_nxt;
            r_status <= w_status_nxt;
        end
    end

    // Head of FIFO falls through; forced to zero while empty so reset shows dat_o=0.
    always_comb begin
        if (r_status.empty) begin
            dat_o = {WIDTH{1'b0}};
        end else begin
            dat_o = r_mem[r_rd_ptr];
        end
    end

    assign empty_o      = r_status.empty;
    assign full_o       = r_status.full;
    assign almostFull_o = r_status.almost_full;
    assign count_o      = r_count;

`ifdef UART_RX_FIFO_OVERRUN_EN
    logic       r_overrun;
    logic [7:0] r_drop_cnt;

    // Sticky overrun flag and saturating drop counter; a drop in the clear cycle wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else if (w_drop) begin
            r_overrun  <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (ovrClr_i) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= 8'd0;
        end
    end

    assign overrun_o = r_overrun;
    assign dropCnt_o = r_drop_cnt;
`else
    logic w_drop_unused;
    assign w_drop_unused = w_drop;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a negedge monitor checks every pop.
module tb_uart_rx_fifo;

    logic       clk_i;
    logic       rst_i;
    logic [7:0] dat_i;
    logic       datEn_i;
    logic       rdEn_i;
    logic [7:0] dat_o;
    logic       empty_o;
    logic       full_o;
    logic       almostFull_o;
    logic [4:0] count_o;
`ifdef UART_RX_FIFO_OVERRUN_EN
    logic       ovrClr_i;
    logic       overrun_o;
    logic [7:0] dropCnt_o;
`endif

    int         n_checks;
    int         n_fail;
    logic [7:0] exp_q [$];
    int         m_count;

    uart_rx_fifo #(
        .WIDTH    (8),
        .DEPTH    (16),
        .AF_LEVEL (12)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
`ifdef UART_RX_FIFO_OVERRUN_EN
        .ovrClr_i     (ovrClr_i),
        .overrun_o    (overrun_o),
        .dropCnt_o    (dropCnt_o),
`endif
        .dat_i        (dat_i),
        .datEn_i      (datEn_i),
        .rdEn_i       (rdEn_i),
        .dat_o        (dat_o),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .almostFull_o (almostFull_o),
        .count_o      (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must return the oldest expected byte.
    always @(negedge clk_i) begin
        if (!rst_i && rdEn_i && !empty_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%0h expected no data", dat_o);
            end else begin
                check("pop_data", {24'd0, dat_o}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One clock of stimulus; wr=1 must follow a cycle with datEn_i low.
    task automatic do_cycle(input logic wr, input logic [7:0] v, input logic rd);
        logic pop;
        logic acc;
        datEn_i = wr;
        dat_i   = v;
        rdEn_i  = rd;
        pop = rd && (m_count > 0);
        acc = wr && ((m_count < 16) || pop);
        if (acc) exp_q.push_back(v);
        m_count = m_count + (acc ? 1 : 0) - (pop ? 1 : 0);
        step();
    endtask

    task automatic idle();
        do_cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic push(input logic [7:0] v);
        do_cycle(1'b1, v, 1'b0);
        idle();
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) do_cycle(1'b0, 8'h00, 1'b1);
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_count  = 0;
        rst_i    = 1'b1;
        datEn_i  = 1'b1;
        dat_i    = 8'h5A;
        rdEn_i   = 1'b0;
`ifdef UART_RX_FIFO_OVERRUN_EN
        ovrClr_i = 1'b0;
`endif
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        step();
        step();
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_empty", 32'(empty_o), 32'd1);
        check("rst_full", 32'(full_o), 32'd0);
        check("rst_af", 32'(almostFull_o), 32'd0);
        check("rst_dat", 32'(dat_o), 32'd0);
        idle();
        check("rst_no_write", 32'(count_o), 32'd0);

        do_cycle(1'b1, 8'hA5, 1'b0);
        check("fwft_dat", 32'(dat_o), 32'hA5);
        check("fwft_empty", 32'(empty_o), 32'd0);
        idle();
        push(8'h3C);
        check("two_count", 32'(count_o), 32'd2);
        do_cycle(1'b0, 8'h00, 1'b1);
        check("pop_next_dat", 32'(dat_o), 32'h3C);
        check("pop_count", 32'(count_o), 32'd1);
        drain(1);
        check("drain_empty", 32'(empty_o), 32'd1);

        for (int i = 0; i < 16; i++) begin
            do_cycle(1'b1, 8'(i), 1'b0);
            if (i == 10) check("af_low_11", 32'(almostFull_o), 32'd0);
            if (i == 11) begin
                check("af_high_12", 32'(almostFull_o), 32'd1);
                check("count_12", 32'(count_o), 32'd12);
            end
            if (i == 14) check("not_full_15", 32'(full_o), 32'd0);
            idle();
        end
        check("full_16", 32'(full_o), 32'd1);
        check("count_16", 32'(count_o), 32'd16);
        push(8'hFF);
        check("drop_count", 32'(count_o), 32'd16);
`ifdef UART_RX_FIFO_OVERRUN_EN
        push(8'hFE);
        push(8'hFD);
        check("ovr_set", 32'(overrun_o), 32'd1);
        check("ovr_cnt", 32'(dropCnt_o), 32'd3);
        ovrClr_i = 1'b1;
        step();
        ovrClr_i = 1'b0;
        check("ovr_clr", 32'(overrun_o), 32'd0);
        check("ovr_cnt_clr", 32'(dropCnt_o), 32'd0);
`endif
        drain(16);
        check("drain16_empty", 32'(empty_o), 32'd1);
        check("drain16_count", 32'(count_o), 32'd0);

        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        do_cycle(1'b1, 8'h77, 1'b1);
        check("full_pushpop_count", 32'(count_o), 32'd16);
        check("full_pushpop_full", 32'(full_o), 32'd1);
        idle();
        drain(16);
        check("after77_empty", 32'(empty_o), 32'd1);

        for (int i = 0; i < 10; i++) push(8'h30 + 8'(i));
        drain(10);
        for (int i = 0; i < 10; i++) push(8'h40 + 8'(i));
        check("wrap_count_10", 32'(count_o), 32'd10);
        check("wrap_af", 32'(almostFull_o), 32'd0);
        drain(10);
        check("wrap_empty", 32'(empty_o), 32'd1);

        do_cycle(1'b1, 8'h11, 1'b1);
        check("empty_pushpop_count", 32'(count_o), 32'd1);
        check("empty_pushpop_dat", 32'(dat_o), 32'h11);
        idle();
        drain(1);
        check("final_empty", 32'(empty_o), 32'd1);
        check("scoreboard_left", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
